// File: rtl/seq11011_frame_tx.sv
// Serial frame transmitter: sends 1,1,0,1,1 sync, then the payload MSB-first, then GAP_LEN zeros.
// All outputs are registers or pure state decodes, so there is no input-to-output path.
module seq11011_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [4:0]    SYNC_PAT = 5'b11011;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic [BW-1:0]     bitcnt_q, bitcnt_n;
  logic [2:0]        sync_q, sync_n;
  logic [GW-1:0]     gap_q, gap_n;
  logic              tx_q, tx_n;
  logic              done_q, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sync_q   <= '0;
      gap_q    <= '0;
      tx_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      shreg_q  <= shreg_n;
      bitcnt_q <= bitcnt_n;
      sync_q   <= sync_n;
      gap_q    <= gap_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    shreg_n  = shreg_q;
    bitcnt_n = bitcnt_q;
    sync_n   = sync_q;
    gap_n    = gap_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_n  = SYNC;
          shreg_n  = data_in;
          sync_n   = '0;
          bitcnt_n = '0;
          gap_n    = '0;
        end
      end
      SYNC: begin
        if (sync_q == 3'd4) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end else begin
          sync_n = sync_q + 3'd1;
        end
      end
      DATA: begin
        if (bitcnt_q == BIT_LAST) begin
          state_n = (GAP_LEN > 0) ? GAP : IDLE;
          gap_n   = '0;
        end else begin
          shreg_n  = shreg_q << 1;
          bitcnt_n = bitcnt_q + BW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_n = IDLE;
        else                   gap_n   = gap_q + GW'(1);
      end
      default: state_n = IDLE;
    endcase

    // Line bit and done flag are precomputed from next-state values so they register in step with the state.
    case (state_n)
      SYNC:    tx_n = SYNC_PAT[3'd4 - sync_n];
      DATA:    tx_n = shreg_n[DATA_W-1];
      default: tx_n = 1'b0;
    endcase
    done_n = (state_n == DATA) && (bitcnt_n == BIT_LAST);
  end

  assign tx_out     = tx_q;
  assign frame_done = done_q;
  assign ready_out  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/seq11011_frame_tx.md
Name: seq11011_frame_tx

Overview:
- Serial frame transmitter; the sending end for the team's 11011 Moore sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Serializes the frame as sync pattern 1,1,0,1,1, then the payload MSB-first, then GAP_LEN idle zeros.
- Drives a single-bit line that feeds a detector's `in` port in loopback benches and system paths.

Parameters:
- DATA_W, 8, payload width in bits; legal range >= 1.
- GAP_LEN, 2, number of forced-zero cycles after the last payload bit; legal range >= 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- data_in  input  DATA_W  payload word; sampled only on the accept edge.
- valid_in  input  1  payload request.
- ready_out  output  1  high only in IDLE.
- tx_out  output  1  serial line; registered (Moore).
- busy  output  1  high in SYNC, DATA and GAP.
- frame_done  output  1  one-cycle pulse, high while the last payload bit is on tx_out.

Behaviour:
- Reset value of every output:
  - rst asserted at any time forces state IDLE immediately (async).
  - tx_out=0, busy=0, frame_done=0, ready_out=1.
  - Shift register and counters are cleared.
- FSM states: IDLE, SYNC, DATA, GAP. All outputs decode from state and registers only; there is no combinational path from inputs to outputs.
- Accept:
  - Occurs on a rising edge with state==IDLE and valid_in=1.
  - data_in is latched into the shift register, and the state goes to SYNC with bit index 0.
- Cycle numbering: cycle 0 is the first cycle after the accept edge.
  - SYNC: tx_out = 1,1,0,1,1 on cycles 0..4.
  - DATA: tx_out = data[DATA_W-1-i] on cycle 5+i, for i = 0..DATA_W-1. frame_done=1 on cycle 4+DATA_W only.
  - GAP: tx_out=0 on cycles 5+DATA_W .. 4+DATA_W+GAP_LEN. GAP is skipped when GAP_LEN=0.
  - IDLE: entered on cycle 5+DATA_W+GAP_LEN. tx_out=0 and ready_out=1 from that cycle on.
- Frame period: the earliest next accept is the edge ending cycle 5+DATA_W+GAP_LEN, so back-to-back frames have period 6+DATA_W+GAP_LEN cycles. There is always at least one zero (the IDLE cycle) between frames.
- Input handling while busy:
  - valid_in is ignored; requests are not queued and no error is flagged.
  - data_in changes have no effect on the frame in flight.
- valid_in=1 held continuously in IDLE: each IDLE-cycle edge accepts a new frame, giving continuous transmission at the period above.
- Counter widths:
  - Bit counter is $clog2(DATA_W+1) bits.
  - Gap counter is $clog2(GAP_LEN+1) bits, minimum 1.
  - Neither counter wraps within a frame.
- Reset mid-frame: the frame is aborted, the latched payload is discarded, and tx_out returns to 0 with no partial continuation after release. The first accept is possible on the first edge with rst=0.
- Payload content is not stuffed. A payload containing 11011 will also trigger a downstream detector; senders that need a single detection per frame must avoid such payloads.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with valid_in=1; then rst released mid-frame at cycle 7.
  - Required response: tx_out=0, busy=0, ready_out=1, frame_done=0 throughout rst. The mid-frame assertion aborts at once: tx_out=0 within the same cycle, IDLE after release.
- Single frame, DATA_W=8, GAP_LEN=2, data_in=8'hA5:
  - Required tx_out on cycles 0..14: 1,1,0,1,1,1,0,1,0,0,1,0,1,0,0.
  - frame_done=1 on cycle 12 only; ready_out=1 from cycle 15.
- Request while busy: valid_in held high with data_in=8'hFF during cycles 0..14 of an 8'h00 frame.
  - Required tx_out: 1,1,0,1,1, then 8 zeros, then 2 zeros.
  - The second frame starts exactly at the accept edge ending cycle 15 (16-cycle period) and carries 8'hFF.
- GAP_LEN=0, DATA_W=4, two back-to-back frames 4'h3 then 4'hC:
  - Required stream: 1,1,0,1,1,0,0,1,1 | 0 (IDLE) | 1,1,0,1,1,1,1,0,0.
  - Period 10 cycles.
- Loopback into the 11011 non-overlapping Moore detector: three frames of 8'h00, GAP_LEN=2.
  - Required response: detector out pulses exactly 3 times, one per frame, each after that frame's fifth sync bit.
- Loopback with payload 8'hDB: detector out pulses twice for the frame (sync plus payload), confirming the documented no-stuffing behaviour.
